// File: rtl/digital_loop_filter.sv
// Bang-bang digital loop filter: synchronised up/down phase error drives a clamped
// integrator plus a proportional kick, with a lock/slip detector on the error sign pattern.
module digital_loop_filter #(
  parameter int CTRL_W     = 8,
  parameter int FRAC_W     = 4,
  parameter int KP         = 4,
  parameter int CTRL_INIT  = 128,
  parameter int LOCK_COUNT = 16,
  parameter int SLIP_COUNT = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              up,
  input  logic              down,
  output logic [CTRL_W-1:0] ctrl,
  output logic              locked,
  output logic              sat
);

  localparam int INT_W    = CTRL_W + FRAC_W;
  localparam int QW       = $clog2(LOCK_COUNT + 1);
  localparam int SW       = $clog2(SLIP_COUNT + 1);
  localparam int CTRL_MAX = (1 << CTRL_W) - 1;

  localparam logic [INT_W-1:0] ACC_MAX  = '1;
  localparam logic [INT_W-1:0] ACC_INIT = INT_W'(CTRL_INIT) << FRAC_W;
  localparam logic [QW-1:0]    QUIET_MAX  = QW'(LOCK_COUNT);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(SLIP_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t             state_reg, state_next;
  logic               up_meta_reg, up_sync_reg, down_meta_reg, down_sync_reg;
  logic [INT_W-1:0]   acc_reg, acc_next;
  logic [CTRL_W-1:0]  ctrl_next;
  logic [QW-1:0]      quiet_reg, quiet_next;
  logic [SW-1:0]      streak_reg, streak_next;
  logic               lastsign_reg;  // 1 = positive
  logic               e_pos, e_neg, qualifying, same_sign, slip;
  logic signed [31:0] ctrl_sum;

  always_comb begin
    e_pos = up_sync_reg & ~down_sync_reg;
    e_neg = ~up_sync_reg & down_sync_reg;

    acc_next = acc_reg;
    if (e_pos && acc_reg != ACC_MAX)
      acc_next = acc_reg + 1'b1;
    else if (e_neg && acc_reg != '0)
      acc_next = acc_reg - 1'b1;

    // Proportional kick is applied on top of the integral part, then clamped to the rails.
    ctrl_sum = $signed({{(32-CTRL_W){1'b0}}, acc_next[INT_W-1:FRAC_W]});
    if (e_pos)
      ctrl_sum = ctrl_sum + KP;
    else if (e_neg)
      ctrl_sum = ctrl_sum - KP;
    if (ctrl_sum < 0)
      ctrl_next = '0;
    else if (ctrl_sum > CTRL_MAX)
      ctrl_next = '1;
    else
      ctrl_next = ctrl_sum[CTRL_W-1:0];

    qualifying = ~(e_pos | e_neg) | (e_pos & ~lastsign_reg) | (e_neg & lastsign_reg);
    same_sign  = (e_pos & lastsign_reg) | (e_neg & ~lastsign_reg);

    quiet_next = '0;
    if (qualifying)
      quiet_next = (quiet_reg == QUIET_MAX) ? quiet_reg : quiet_reg + 1'b1;
    streak_next = '0;
    if (same_sign)
      streak_next = (streak_reg == STREAK_MAX) ? streak_reg : streak_reg + 1'b1;

    state_next = state_reg;
    slip       = 1'b0;
    case (state_reg)
      IDLE:    state_next = ACQUIRE;
      ACQUIRE: if (quiet_next >= QUIET_MAX) state_next = LOCKED;
      LOCKED: begin
        if (streak_next >= STREAK_MAX) begin
          state_next = ACQUIRE;
          slip       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!enable) begin
      state_next = IDLE;
      slip       = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      up_meta_reg   <= 1'b0;
      up_sync_reg   <= 1'b0;
      down_meta_reg <= 1'b0;
      down_sync_reg <= 1'b0;
      state_reg     <= IDLE;
      acc_reg       <= ACC_INIT;
      ctrl          <= CTRL_W'(CTRL_INIT);
      sat           <= 1'b0;
      locked        <= 1'b0;
      quiet_reg     <= '0;
      streak_reg    <= '0;
      lastsign_reg  <= 1'b1;
    end else begin
      up_meta_reg   <= up;
      up_sync_reg   <= up_meta_reg;
      down_meta_reg <= down;
      down_sync_reg <= down_meta_reg;
      state_reg     <= state_next;
      locked        <= (state_next == LOCKED);
      if (enable) begin
        acc_reg    <= acc_next;
        ctrl       <= ctrl_next;
        sat        <= (acc_next == '0) || (acc_next == ACC_MAX);
        quiet_reg  <= slip ? '0 : quiet_next;
        streak_reg <= streak_next;
        if (e_pos | e_neg)
          lastsign_reg <= e_pos;
      end
    end
  end

endmodule
